// File: rtl/mem_port_arbiter_if.sv
// Bus between the core's fetch/data ports, the arbiter and a single-port synchronous-read memory.
// The master side is the core plus memory array; the slave side is the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned MEM_ADDR_W = 19
) ();
  logic                  imem_req;
  logic [31:0]           imem_addr;
  logic                  imem_ack;
  logic [31:0]           imem_rdata;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [31:0]           dmem_addr;
  logic [31:0]           dmem_wdata;
  logic                  dmem_ack;
  logic [31:0]           dmem_rdata;

  logic                  mem_en;
  logic                  mem_wr_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0]           mem_wr_data;
  logic [31:0]           mem_rd_data;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_rd_data,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata, mem_en, mem_wr_en, mem_addr, mem_wr_data
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_rd_data,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata, mem_en, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and data ports, with an
// MMIO window (0xF000_000x) for signature and halt writes that never reaches memory.
module mem_port_arbiter #(
  parameter int unsigned MEM_ADDR_W = 19,
  parameter logic [31:0] HALT_DATA  = 32'hCAFECAFE
) (
  input  logic               sysclk,
  input  logic               rst_in,
  mem_port_arbiter_if.slave  bus,
  output logic               sig_valid,
  output logic [31:0]        sig_data,
  output logic               halted
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [31:0] HaltAddr = 32'hF000_0000;
  localparam logic [31:0] SigAddr  = 32'hF000_0004;

  state_e                state_q, state_d;
  logic                  last_data_q, last_data_d;
  logic                  id_data_q, id_data_d;
  logic                  rd_pass_q, rd_pass_d;
  logic                  halt_wr_q, halt_wr_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wr_data_q, mem_wr_data_d;
  logic                  imem_ack_q, imem_ack_d;
  logic                  dmem_ack_q, dmem_ack_d;
  logic                  sig_valid_q, sig_valid_d;
  logic [31:0]           sig_data_q, sig_data_d;
  logic                  halted_q, halted_d;

  logic                  gnt_imem, gnt_dmem;
  logic [31:0]           sel_addr;
  logic [31:0]           sel_wdata;
  logic                  sel_we;
  logic                  sel_mmio;
  logic                  unused_addr_lo;

  // On a tie the requester not granted last wins.
  always_comb begin
    gnt_imem = 1'b0;
    gnt_dmem = 1'b0;
    if (state_q == StIdle && !halted_q) begin
      gnt_imem = bus.imem_req && (!bus.dmem_req || last_data_q);
      gnt_dmem = bus.dmem_req && (!bus.imem_req || !last_data_q);
    end
  end

  always_comb begin
    sel_addr  = gnt_dmem ? bus.dmem_addr : bus.imem_addr;
    sel_wdata = gnt_dmem ? bus.dmem_wdata : 32'h0;
    sel_we    = gnt_dmem && bus.dmem_we;
    sel_mmio  = (sel_addr[31:28] == 4'hF);
  end

  assign unused_addr_lo = ^sel_addr[1:0];

  always_comb begin
    state_d       = state_q;
    last_data_d   = last_data_q;
    id_data_d     = id_data_q;
    rd_pass_d     = rd_pass_q;
    halt_wr_d     = halt_wr_q;
    mem_en_d      = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    imem_ack_d    = 1'b0;
    dmem_ack_d    = 1'b0;
    sig_valid_d   = 1'b0;
    sig_data_d    = sig_data_q;
    halted_d      = halted_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_imem || gnt_dmem) begin
          state_d       = StAccess;
          last_data_d   = gnt_dmem;
          id_data_d     = gnt_dmem;
          mem_en_d      = !sel_mmio;
          mem_wr_en_d   = !sel_mmio && sel_we;
          mem_addr_d    = sel_addr[MEM_ADDR_W+1:2];
          mem_wr_data_d = sel_wdata;
          // Only non-MMIO reads forward memory data; everything else answers zero.
          rd_pass_d     = !sel_mmio && !sel_we;
          halt_wr_d     = sel_we && (sel_addr[31:2] == HaltAddr[31:2])
                          && (sel_wdata == HALT_DATA);
          if (sel_we && (sel_addr[31:2] == SigAddr[31:2])) begin
            sig_valid_d = 1'b1;
            sig_data_d  = sel_wdata;
          end
        end
      end
      StAccess: begin
        state_d    = StResp;
        imem_ack_d = !id_data_q;
        dmem_ack_d = id_data_q;
        if (halt_wr_q) begin
          halted_d = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst_in) begin
      state_q       <= StIdle;
      last_data_q   <= 1'b1;
      id_data_q     <= 1'b0;
      rd_pass_q     <= 1'b0;
      halt_wr_q     <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      imem_ack_q    <= 1'b0;
      dmem_ack_q    <= 1'b0;
      sig_valid_q   <= 1'b0;
      sig_data_q    <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_data_q   <= last_data_d;
      id_data_q     <= id_data_d;
      rd_pass_q     <= rd_pass_d;
      halt_wr_q     <= halt_wr_d;
      mem_en_q      <= mem_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      imem_ack_q    <= imem_ack_d;
      dmem_ack_q    <= dmem_ack_d;
      sig_valid_q   <= sig_valid_d;
      sig_data_q    <= sig_data_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.imem_ack    = imem_ack_q;
  assign bus.dmem_ack    = dmem_ack_q;
  // Read data arrives from memory in RESP, so it is gated rather than registered.
  assign bus.imem_rdata  = (imem_ack_q && rd_pass_q) ? bus.mem_rd_data : 32'h0;
  assign bus.dmem_rdata  = (dmem_ack_q && rd_pass_q) ? bus.mem_rd_data : 32'h0;
  assign sig_valid       = sig_valid_q;
  assign sig_data        = sig_data_q;
  assign halted          = halted_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous-read memory model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        sig_valid;
  logic [31:0] sig_data;
  logic        halted;
  int          checks;
  int          errors;
  int          bad_cnt;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_q;

  mem_port_arbiter_if #(.MEM_ADDR_W(19)) bus ();

  mem_port_arbiter #(
    .MEM_ADDR_W(19),
    .HALT_DATA (32'hCAFECAFE)
  ) dut (
    .sysclk   (clk),
    .rst_in   (rst),
    .bus      (bus),
    .sig_valid(sig_valid),
    .sig_data (sig_data),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr_en) mem[bus.mem_addr[9:0]] <= bus.mem_wr_data;
      else               rd_q <= mem[bus.mem_addr[9:0]];
    end
  end
  assign bus.mem_rd_data = rd_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.imem_req   = 1'b0;
    bus.imem_addr  = 32'h0;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = 32'h0;
    bus.dmem_wdata = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd_q   = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h00500093;
    mem[8] = 32'h11112222;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_imem_ack", {31'h0, bus.imem_ack}, 32'h0);
    check("rst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_sig_data", sig_data, 32'h0);
    rst = 1'b0;
    step();

    // Single fetch
    bus.imem_req  = 1'b1;
    bus.imem_addr = 32'h80000010;
    step();
    check("fetch_mem_en", {31'h0, bus.mem_en}, 32'h1);
    check("fetch_mem_addr", {13'h0, bus.mem_addr}, 32'h4);
    check("fetch_wr_en", {31'h0, bus.mem_wr_en}, 32'h0);
    step();
    check("fetch_ack", {31'h0, bus.imem_ack}, 32'h1);
    check("fetch_rdata", bus.imem_rdata, 32'h00500093);
    check("fetch_dack", {31'h0, bus.dmem_ack}, 32'h0);
    bus.imem_req = 1'b0;
    step();
    check("fetch_ack_gone", {31'h0, bus.imem_ack}, 32'h0);
    check("fetch_rdata_gone", bus.imem_rdata, 32'h0);
    check("fetch_en_gone", {31'h0, bus.mem_en}, 32'h0);

    // Data write then read
    bus.dmem_req   = 1'b1;
    bus.dmem_we    = 1'b1;
    bus.dmem_addr  = 32'h00000100;
    bus.dmem_wdata = 32'h12345678;
    step();
    check("wr_en", {31'h0, bus.mem_wr_en}, 32'h1);
    check("wr_mem_en", {31'h0, bus.mem_en}, 32'h1);
    check("wr_addr", {13'h0, bus.mem_addr}, 32'h40);
    check("wr_data", bus.mem_wr_data, 32'h12345678);
    step();
    check("wr_ack", {31'h0, bus.dmem_ack}, 32'h1);
    check("wr_rdata", bus.dmem_rdata, 32'h0);
    bus.dmem_req = 1'b0;
    step();
    bus.dmem_req = 1'b1;
    bus.dmem_we  = 1'b0;
    step();
    check("rd_mem_en", {31'h0, bus.mem_en}, 32'h1);
    check("rd_wr_en", {31'h0, bus.mem_wr_en}, 32'h0);
    check("rd_addr", {13'h0, bus.mem_addr}, 32'h40);
    step();
    check("rd_ack", {31'h0, bus.dmem_ack}, 32'h1);
    check("rd_rdata", bus.dmem_rdata, 32'h12345678);
    bus.dmem_req = 1'b0;
    step();

    // MMIO signature and halt writes
    bus.dmem_req   = 1'b1;
    bus.dmem_we    = 1'b1;
    bus.dmem_addr  = 32'hF0000004;
    bus.dmem_wdata = 32'hDEADBEEF;
    step();
    check("sig_valid", {31'h0, sig_valid}, 32'h1);
    check("sig_data", sig_data, 32'hDEADBEEF);
    check("sig_mem_en", {31'h0, bus.mem_en}, 32'h0);
    step();
    check("sig_ack", {31'h0, bus.dmem_ack}, 32'h1);
    check("sig_valid_pulse", {31'h0, sig_valid}, 32'h0);
    check("sig_data_hold", sig_data, 32'hDEADBEEF);
    bus.dmem_req = 1'b0;
    step();
    bus.dmem_req   = 1'b1;
    bus.dmem_addr  = 32'hF0000000;
    bus.dmem_wdata = 32'h00000001;
    step();
    check("badhalt_mem_en", {31'h0, bus.mem_en}, 32'h0);
    step();
    check("badhalt_ack", {31'h0, bus.dmem_ack}, 32'h1);
    bus.dmem_req = 1'b0;
    step();
    check("badhalt_halted", {31'h0, halted}, 32'h0);

    // Reset during ACCESS of a read, with a fetch pending
    bus.dmem_req  = 1'b1;
    bus.dmem_we   = 1'b0;
    bus.dmem_addr = 32'h00000100;
    step();
    check("rstmid_mem_en", {31'h0, bus.mem_en}, 32'h1);
    rst           = 1'b1;
    bus.imem_req  = 1'b1;
    bus.imem_addr = 32'h00000010;
    step();
    check("rstmid_dack", {31'h0, bus.dmem_ack}, 32'h0);
    check("rstmid_iack", {31'h0, bus.imem_ack}, 32'h0);
    check("rstmid_mem_en0", {31'h0, bus.mem_en}, 32'h0);
    check("rstmid_sig_data", sig_data, 32'h0);
    check("rstmid_mem_addr", {13'h0, bus.mem_addr}, 32'h0);
    rst = 1'b0;
    step();
    check("rstmid_first_addr", {13'h0, bus.mem_addr}, 32'h4);
    step();
    check("rstmid_first_iack", {31'h0, bus.imem_ack}, 32'h1);
    check("rstmid_first_dack", {31'h0, bus.dmem_ack}, 32'h0);
    bus.imem_req = 1'b0;
    step();
    step();
    check("rstmid_second_addr", {13'h0, bus.mem_addr}, 32'h40);
    step();
    check("rstmid_second_dack", {31'h0, bus.dmem_ack}, 32'h1);
    check("rstmid_second_rdata", bus.dmem_rdata, 32'h12345678);
    bus.dmem_req = 1'b0;
    step();

    // Halt write, then a fetch must starve
    bus.dmem_req   = 1'b1;
    bus.dmem_we    = 1'b1;
    bus.dmem_addr  = 32'hF0000000;
    bus.dmem_wdata = 32'hCAFECAFE;
    step();
    check("halt_not_yet", {31'h0, halted}, 32'h0);
    check("halt_mem_en", {31'h0, bus.mem_en}, 32'h0);
    step();
    check("halt_set", {31'h0, halted}, 32'h1);
    check("halt_ack", {31'h0, bus.dmem_ack}, 32'h1);
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    step();
    bus.imem_req  = 1'b1;
    bus.imem_addr = 32'h00000010;
    bad_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.imem_ack || bus.mem_en) bad_cnt++;
    end
    check("halt_starve", bad_cnt, 0);
    check("halt_sticky", {31'h0, halted}, 32'h1);

    // Halt recovery via reset with fetch held
    rst = 1'b1;
    step();
    check("recover_halted", {31'h0, halted}, 32'h0);
    rst = 1'b0;
    step();
    check("recover_mem_en", {31'h0, bus.mem_en}, 32'h1);
    step();
    check("recover_ack", {31'h0, bus.imem_ack}, 32'h1);
    check("recover_rdata", bus.imem_rdata, 32'h00500093);
    bus.imem_req = 1'b0;
    step();

    // Contention from reset release: I, D, I, D
    rst = 1'b1;
    step();
    rst            = 1'b0;
    bus.imem_req   = 1'b1;
    bus.imem_addr  = 32'h00000010;
    bus.dmem_req   = 1'b1;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = 32'h00000020;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("cont_iack_t%0d", k), {31'h0, bus.imem_ack},
            (k == 2 || k == 8) ? 32'h1 : 32'h0);
      check($sformatf("cont_dack_t%0d", k), {31'h0, bus.dmem_ack},
            (k == 5 || k == 11) ? 32'h1 : 32'h0);
      if (k == 2) check("cont_irdata", bus.imem_rdata, 32'h00500093);
      if (k == 5) check("cont_drdata", bus.dmem_rdata, 32'h11112222);
    end
    idle_inputs();
    step();
    step();
    check("cont_quiet", {31'h0, bus.mem_en}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
